// File: rtl/common_pkg.sv
// Project-wide constants that are not tied to one datapath.
package common_pkg;

  localparam int MAX_SIM_BYTS = 32;

endpackage

// File: rtl/redun_mont_pkg.sv
// Shared sizing and state encoding for the modular squaring unit datapath.
// Used by the input unpacker, the output packer and their benches.
package redun_mont_pkg;

  localparam int TOT_BITS = 1024;
  localparam int AXI_LEN  = 32;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} unpack_state_t;

  // Width of shard idx once the word is cut at out_bits; only the top shard can be short.
  function automatic int shard_width(input int idx, input int out_bits, input int axi_len);
    int rem;
    rem = out_bits - idx * axi_len;
    return (rem < axi_len) ? rem : axi_len;
  endfunction

endpackage

// File: rtl/axis_keep_mask.sv
// Combinational AXI4-Stream byte masking: bytes whose tkeep bit is low are forced to zero.
module axis_keep_mask #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  output logic [DATA_W-1:0]   masked
);

  always_comb begin
    // NOTE: assign a default before any conditional write so no latch is inferred.
    masked = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (keep[b]) masked[b*8 +: 8] = data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/msu_axis_unpack.sv
// Assembles a little-endian AXI4-Stream frame into one OUT_BITS word for the squaring core.
// Optional build macro MSU_UNPACK_ERR_CNT_EN adds a saturating malformed-frame counter (err_cnt).
module msu_axis_unpack
  import redun_mont_pkg::*;
#(
  parameter int AXI_LEN  = redun_mont_pkg::AXI_LEN,
  parameter int OUT_BITS = redun_mont_pkg::TOT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [AXI_LEN-1:0]   s_axis_tdata,
  input  logic [AXI_LEN/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 o_val,
  input  logic                 o_rdy,
  output logic [OUT_BITS-1:0]  o_dat,
  output logic                 o_short,
  output logic                 o_long
`ifdef MSU_UNPACK_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int NUM_BEATS = (OUT_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

  unpack_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [AXI_LEN-1:0] masked;
  logic               beat_ok;

  axis_keep_mask #(.DATA_W(AXI_LEN)) u_keep_mask (
    .data   (s_axis_tdata),
    .keep   (s_axis_tkeep),
    .masked (masked)
  );

  assign beat_ok = s_axis_tvalid & s_axis_tready;

  // cnt stops at LAST_IDX; leaving LOAD is decided from it, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      s_axis_tready <= 1'b0;
      o_val         <= 1'b0;
      o_short       <= 1'b0;
      o_long        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          cnt           <= '0;
          state         <= LOAD;
        end
        LOAD: begin
          if (beat_ok) begin
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              o_val         <= 1'b1;
              o_short       <= (cnt != LAST_IDX);
              state         <= OUT;
            end else if (cnt == LAST_IDX) begin
              o_long <= 1'b1;
              state  <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat_ok && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            o_val         <= 1'b1;
            state         <= OUT;
          end
        end
        OUT: begin
          if (o_rdy) begin
            o_val   <= 1'b0;
            o_short <= 1'b0;
            o_long  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One register per beat slot; the top slot is cut to whatever remains of OUT_BITS.
  for (genvar i = 0; i < NUM_BEATS; i++) begin : g_shard
    localparam int LO = i * AXI_LEN;
    localparam int W  = shard_width(i, OUT_BITS, AXI_LEN);

    logic [W-1:0] shard_q;
    logic         we;

    assign we = beat_ok && (state == LOAD) && (cnt == CNT_W'(i));

    always_ff @(posedge clk) begin
      // NOTE: data registers are reset too, because o_dat has a defined reset value of zero.
      if (reset || state == IDLE) shard_q <= '0;
      else if (we)                shard_q <= masked[W-1:0];
    end

    assign o_dat[LO +: W] = shard_q;
  end

`ifdef MSU_UNPACK_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (o_val && o_rdy && (o_short || o_long) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_msu_axis_unpack.sv
// Self-checking bench for msu_axis_unpack: a 64-bit and a truncating 40-bit instance share one stream.
module tb_msu_axis_unpack;
  import redun_mont_pkg::*;
  import common_pkg::*;

  localparam int OUT_A     = 64;
  localparam int OUT_B     = 40;
  localparam int KW        = AXI_LEN / 8;
  localparam int NB        = (OUT_A + AXI_LEN - 1) / AXI_LEN;
  localparam int MAX_BEATS = MAX_SIM_BYTS / KW;

  typedef struct {
    logic [AXI_LEN-1:0] d;
    logic [KW-1:0]      k;
    bit                 l;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_axis_tvalid;
  logic [AXI_LEN-1:0] s_axis_tdata;
  logic [KW-1:0]      s_axis_tkeep;
  logic               s_axis_tlast;
  logic               o_rdy;
  logic               tready_a, tready_b, o_val_a, o_val_b;
  logic               o_short_a, o_short_b, o_long_a, o_long_b;
  logic [OUT_A-1:0]   o_dat_a;
  logic [OUT_B-1:0]   o_dat_b;
`ifdef MSU_UNPACK_ERR_CNT_EN
  logic [15:0]        err_cnt_a, err_cnt_b;
`endif

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  msu_axis_unpack #(.AXI_LEN(AXI_LEN), .OUT_BITS(OUT_A)) dut_a (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready_a), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .o_val(o_val_a), .o_rdy(o_rdy), .o_dat(o_dat_a), .o_short(o_short_a), .o_long(o_long_a)
`ifdef MSU_UNPACK_ERR_CNT_EN
    , .err_cnt(err_cnt_a)
`endif
  );

  msu_axis_unpack #(.AXI_LEN(AXI_LEN), .OUT_BITS(OUT_B)) dut_b (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready_b), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .o_val(o_val_b), .o_rdy(o_rdy), .o_dat(o_dat_b), .o_short(o_short_b), .o_long(o_long_b)
`ifdef MSU_UNPACK_ERR_CNT_EN
    , .err_cnt(err_cnt_b)
`endif
  );

  // Byte-level reference: byte y of beat b lands at byte b*KW+y of the word; beats past NB vanish.
  function automatic logic [OUT_A-1:0] model_word(input beat_t f[$]);
    logic [OUT_A-1:0] w;
    w = '0;
    for (int b = 0; b < f.size() && b < NB; b++)
      for (int y = 0; y < KW; y++)
        if (f[b].k[y]) w[(b*KW + y)*8 +: 8] = f[b].d[y*8 +: 8];
    return w;
  endfunction

  function automatic beat_t mk(input logic [AXI_LEN-1:0] d, input logic [KW-1:0] k, input bit l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  task automatic send_beat(input beat_t bt);
    int t;
    t = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = bt.d; s_axis_tkeep = bt.k; s_axis_tlast = bt.l;
    while (!tready_a && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (tready_a !== 1'b1) begin errors++; $display("FAIL beat_accept_timeout: tready=%b want 1", tready_a); end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  // Sends a frame, then checks the word, its stability under backpressure and the handoff gap.
  task automatic run_frame(input beat_t f[$], input int gap_max, input int hold,
                           input bit use_exp, input logic [OUT_A-1:0] exp_in);
    logic [OUT_A-1:0] exp;
    bit es, el;
    exp = use_exp ? exp_in : model_word(f);
    es  = f.size() < NB;
    el  = f.size() > NB;
    for (int b = 0; b < f.size(); b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        s_axis_tvalid = 1'b0; s_axis_tdata = AXI_LEN'($urandom); @(negedge clk);
      end
      send_beat(f[b]);
      if (b != f.size() - 1) begin
        checks++;
        if (o_val_a !== 1'b0 || o_val_b !== 1'b0) begin
          errors++; $display("FAIL early_o_val: beat %0d o_val=%b/%b want 0", b, o_val_a, o_val_b);
        end
      end
    end
    checks++;
    if (o_val_a !== 1'b1 || o_val_b !== 1'b1) begin
      errors++; $display("FAIL o_val_latency: o_val=%b/%b want 1", o_val_a, o_val_b);
    end
    checks++;
    if (o_dat_a !== exp) begin errors++; $display("FAIL o_dat_a: got %h want %h", o_dat_a, exp); end
    checks++;
    if (o_dat_b !== exp[OUT_B-1:0]) begin
      errors++; $display("FAIL o_dat_b_trunc: got %h want %h", o_dat_b, exp[OUT_B-1:0]);
    end
    checks++;
    if ({o_short_a, o_long_a, o_short_b, o_long_b} !== {es, el, es, el}) begin
      errors++;
      $display("FAIL flags: got short/long %b%b %b%b want %b%b", o_short_a, o_long_a, o_short_b, o_long_b, es, el);
    end
    // A garbage beat is offered through OUT and the following IDLE cycle; it must never be taken.
    s_axis_tvalid = 1'b1; s_axis_tdata = AXI_LEN'($urandom); s_axis_tkeep = '1; s_axis_tlast = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (o_val_a !== 1'b1 || o_dat_a !== exp || o_dat_b !== exp[OUT_B-1:0] || tready_a !== 1'b0 || tready_b !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d o_val=%b o_dat=%h tready=%b/%b want 1 %h 0/0", c, o_val_a, o_dat_a, tready_a, tready_b, exp);
      end
    end
    o_rdy = 1'b1;
    @(negedge clk);
    o_rdy = 1'b0;
    if ((es || el) && exp_err < 16'hFFFF) exp_err++;
    checks++;
    if (o_val_a !== 1'b0 || o_val_b !== 1'b0 || tready_a !== 1'b0 || tready_b !== 1'b0) begin
      errors++; $display("FAIL handoff_gap: o_val=%b/%b tready=%b/%b want 0/0 0/0", o_val_a, o_val_b, tready_a, tready_b);
    end
`ifdef MSU_UNPACK_ERR_CNT_EN
    checks++;
    if (err_cnt_a !== 16'(exp_err) || err_cnt_b !== 16'(exp_err)) begin
      errors++; $display("FAIL err_cnt_track: got %0d/%0d want %0d", err_cnt_a, err_cnt_b, exp_err);
    end
`endif
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    checks++;
    if (tready_a !== 1'b1 || tready_b !== 1'b1) begin
      errors++; $display("FAIL ready_after_gap: tready=%b/%b want 1/1", tready_a, tready_b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_axis_tvalid = 1'b0; o_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tready_a, o_val_a, o_short_a, o_long_a, tready_b, o_val_b, o_short_b, o_long_b} !== 8'b0 ||
        o_dat_a !== '0 || o_dat_b !== '0) begin
      errors++;
      $display("FAIL reset_values: tready=%b o_val=%b o_dat=%h short=%b long=%b want all 0", tready_a, o_val_a, o_dat_a, o_short_a, o_long_a);
    end
`ifdef MSU_UNPACK_ERR_CNT_EN
    checks++;
    if (err_cnt_a !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_a); end
`endif
    reset = 1'b0;
    exp_err = 0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    beat_t f[$];
    f.push_back(mk(32'h11111111, 4'hF, 1'b0));
    f.push_back(mk(32'h22222222, 4'hF, 1'b1));
    run_frame(f, 0, 0, 1'b1, 64'h2222222211111111);
  endtask

  task automatic test_short_frame();
    beat_t f[$];
    f.push_back(mk(32'h00000002, 4'hF, 1'b1));
    run_frame(f, 0, 1, 1'b1, 64'h0000000000000002);
  endtask

  task automatic test_overlong();
    beat_t f[$];
    f.push_back(mk(32'h01234567, 4'hF, 1'b0));
    f.push_back(mk(32'h89ABCDEF, 4'hF, 1'b0));
    f.push_back(mk(32'hDEADBEEF, 4'hF, 1'b0));
    f.push_back(mk(32'hCAFEF00D, 4'hF, 1'b1));
    run_frame(f, 1, 1, 1'b1, 64'h89ABCDEF01234567);
  endtask

  task automatic test_keep_mask();
    beat_t f[$];
    f.push_back(mk(32'hAABBCCDD, 4'b0101, 1'b0));
    f.push_back(mk(32'h00000000, 4'hF, 1'b1));
    run_frame(f, 0, 0, 1'b1, 64'h0000000000BB00DD);
  endtask

  task automatic test_backpressure_reset();
    beat_t f[$];
    f.push_back(mk(32'h5A5A0F0F, 4'hF, 1'b0));
    f.push_back(mk(32'hFFFFFFFF, 4'hF, 1'b1));
    run_frame(f, 0, 10, 1'b1, 64'hFFFFFFFF5A5A0F0F);
    send_beat(mk(32'h12345678, 4'hF, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    checks++;
    if ({tready_a, o_val_a, o_short_a, o_long_a, tready_b, o_val_b} !== 6'b0 || o_dat_a !== '0 || o_dat_b !== '0) begin
      errors++;
      $display("FAIL midframe_reset: tready=%b o_val=%b o_dat=%h short=%b long=%b want all 0", tready_a, o_val_a, o_dat_a, o_short_a, o_long_a);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (o_val_a !== 1'b0 || o_val_b !== 1'b0) begin
        errors++; $display("FAIL lost_frame_o_val: cycle %0d o_val=%b/%b want 0", c, o_val_a, o_val_b);
      end
    end
  endtask

`ifdef MSU_UNPACK_ERR_CNT_EN
  task automatic test_err_cnt();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    @(negedge clk);
    test_short_frame();
    test_overlong();
    checks++;
    if (err_cnt_a !== 16'd2 || err_cnt_b !== 16'd2) begin
      errors++; $display("FAIL err_cnt_pair: got %0d/%0d want 2", err_cnt_a, err_cnt_b);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      beat_t f[$];
      int len;
      len = $urandom_range(1, MAX_BEATS);
      for (int b = 0; b < len; b++)
        f.push_back(mk(AXI_LEN'($urandom), ($urandom_range(0, 1) == 1) ? KW'($urandom) : '1, b == len - 1));
      run_frame(f, 2, $urandom_range(0, 3), 1'b0, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; o_rdy = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overlong();
    test_keep_mask();
    test_backpressure_reset();
`ifdef MSU_UNPACK_ERR_CNT_EN
    test_err_cnt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
